// File: rtl/rtype_pkg.sv
// Shared constants, FSM state and field-bundle type for the R-type instruction-memory writer.
package rtype_pkg;

  localparam logic [5:0] RTYPE_OPCODE = 6'b000000;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_fields_t;

  // Functions the R-type datapath actually implements.
  function automatic logic funct_is_legal(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/rtype_imem_writer_if.sv
// Field stream, instruction-memory write port and load status of rtype_imem_writer.
interface rtype_imem_writer_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;

  modport master (
    output start, in_valid, in_rs, in_rt, in_rd, in_shamt, in_funct, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_run, done, count, err
  );

  modport slave (
    input  start, in_valid, in_rs, in_rt, in_rd, in_shamt, in_funct, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, core_run, done, count, err
  );

endinterface

// File: rtl/rtype_imem_writer_encoder.sv
// Packs R-type fields into a 32-bit instruction word and flags legal funct codes.
// Funct checking is compiled in only when RTYPE_FUNCT_CHECK_EN is defined.
module rtype_encoder
  import rtype_pkg::*;
(
  input  rtype_fields_t i_fields,
  output logic [31:0]   o_word_c,
  output logic          o_legal_c
);

  assign o_word_c = {RTYPE_OPCODE, i_fields.rs, i_fields.rt, i_fields.rd,
                     i_fields.shamt, i_fields.funct};

`ifdef RTYPE_FUNCT_CHECK_EN
  assign o_legal_c = funct_is_legal(i_fields.funct);
`else
  assign o_legal_c = 1'b1;
`endif

endmodule

// File: rtl/rtype_imem_writer.sv
// Loads a stream of R-type field bundles into instruction memory, then releases the core.
// Optional illegal-funct rejection: RTYPE_FUNCT_CHECK_EN.
module rtype_imem_writer
  import rtype_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  rtype_imem_writer_if.slave bus
);

  localparam int unsigned   ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [ADDR_W:0]     r_ptr;
  logic                r_in_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_core_run;
  logic                r_done;
  logic                r_err;

  rtype_fields_t       w_fields;
  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_accept;

  assign w_fields = '{rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                      shamt: bus.in_shamt, funct: bus.in_funct};
  assign w_accept = bus.in_valid && r_in_ready;

  rtype_encoder u_encoder (
    .i_fields  (w_fields),
    .o_word_c  (w_word),
    .o_legal_c (w_legal)
  );

  // Pointer doubles as the written-instruction count; it stops at DEPTH and never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_run <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= LOAD;
            r_ptr      <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_ptr[ADDR_W-1:0];
              r_wdata <= w_word;
              r_ptr   <= r_ptr + PTR_ONE;
              if (bus.in_last || (r_ptr == LAST_PTR)) begin
                r_state    <= DONE;
                r_in_ready <= 1'b0;
              end
              if (!bus.in_last && (r_ptr == LAST_PTR)) r_err <= 1'b1;
            end else begin
              r_err <= 1'b1;
              if (bus.in_last) begin
                r_state    <= DONE;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            r_state    <= LOAD;
            r_ptr      <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_core_run <= 1'b0;
            r_done     <= 1'b0;
          end else begin
            r_core_run <= 1'b1;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_run   = r_core_run;
  assign bus.done       = r_done;
  assign bus.count      = r_ptr;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_rtype_imem_writer.sv
// Directed bench for rtype_imem_writer: a DEPTH=32 instance and a DEPTH=4 instance for truncation.
module tb_rtype_imem_writer;

  logic clock;
  logic reset;

  int unsigned n_cmp;
  int unsigned n_bad;

  rtype_imem_writer_if #(.DEPTH(32)) bus ();
  rtype_imem_writer_if #(.DEPTH(4))  bus4 ();

  rtype_imem_writer #(.DEPTH(32)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  rtype_imem_writer #(.DEPTH(4)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic last);
    bus.in_valid = valid;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_shamt = sh;
    bus.in_funct = fn;
    bus.in_last  = last;
  endtask

  // Back-to-back stream: sub, and, or (all fields max), slt (last).
  logic [4:0]  s_rs [4] = '{5'd4, 5'd7, 5'd31, 5'd0};
  logic [4:0]  s_rt [4] = '{5'd5, 5'd8, 5'd31, 5'd0};
  logic [4:0]  s_rd [4] = '{5'd6, 5'd9, 5'd31, 5'd1};
  logic [4:0]  s_sh [4] = '{5'd0, 5'd0, 5'd31, 5'd2};
  logic [5:0]  s_fn [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
  logic [31:0] s_wd [4] = '{32'h0085_3022, 32'h00E8_4824, 32'h03FF_FFE5, 32'h0000_08AA};
  logic [31:0] d4_wd [4] = '{32'h0000_0020, 32'h0020_0020, 32'h0040_0020, 32'h0060_0020};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus4.start = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    bus4.in_valid = 1'b0;
    bus4.in_rs = '0; bus4.in_rt = '0; bus4.in_rd = '0;
    bus4.in_shamt = '0; bus4.in_funct = 6'h20; bus4.in_last = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",       32'(bus.imem_we), 32'd0);
    chk("rst_addr",     32'(bus.imem_addr), 32'd0);
    chk("rst_wdata",    bus.imem_wdata, 32'd0);
    chk("rst_core_run", 32'(bus.core_run), 32'd0);
    chk("rst_done",     32'(bus.done), 32'd0);
    chk("rst_count",    32'(bus.count), 32'd0);
    chk("rst_err",      32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Single add with in_last.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("load_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    chk("add_we",    32'(bus.imem_we), 32'd1);
    chk("add_addr",  32'(bus.imem_addr), 32'd0);
    chk("add_wdata", bus.imem_wdata, 32'h0022_1820);
    chk("add_count", 32'(bus.count), 32'd1);
    chk("add_done_not_with_we", 32'(bus.done), 32'd0);
    chk("add_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("add_we_off",   32'(bus.imem_we), 32'd0);
    chk("add_done",     32'(bus.done), 32'd1);
    chk("add_core_run", 32'(bus.core_run), 32'd1);
    chk("add_count_hold", 32'(bus.count), 32'd1);
    chk("add_err",      32'(bus.err), 32'd0);

    // Bundles offered in DONE are ignored.
    drive(1'b1, 5'd9, 5'd9, 5'd9, 5'd0, 6'h20, 1'b0);
    tick();
    chk("done_ignore_we",    32'(bus.imem_we), 32'd0);
    chk("done_ignore_count", 32'(bus.count), 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);

    // Restart from DONE, then stream four bundles with in_valid held high.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_core_run", 32'(bus.core_run), 32'd0);
    chk("restart_done",     32'(bus.done), 32'd0);
    chk("restart_count",    32'(bus.count), 32'd0);
    chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s_rs[i], s_rt[i], s_rd[i], s_sh[i], s_fn[i], (i == 3));
      bus.start = (i == 2);
      tick();
      chk($sformatf("stream%0d_we", i),    32'(bus.imem_we), 32'd1);
      chk($sformatf("stream%0d_addr", i),  32'(bus.imem_addr), 32'(i));
      chk($sformatf("stream%0d_wdata", i), bus.imem_wdata, s_wd[i]);
      chk($sformatf("stream%0d_count", i), 32'(bus.count), 32'(i + 1));
    end
    bus.start = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    tick();
    chk("stream_done",  32'(bus.done), 32'd1);
    chk("stream_count", 32'(bus.count), 32'd4);
    chk("stream_err",   32'(bus.err), 32'd0);

    // Funct 0x3F followed by sub rs=4 rt=5 rd=6 (last).
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive(1'b1, 5'd1, 5'd1, 5'd1, 5'd0, 6'h3F, 1'b0);
    tick();
`ifdef RTYPE_FUNCT_CHECK_EN
    chk("bad_funct_we",    32'(bus.imem_we), 32'd0);
    chk("bad_funct_count", 32'(bus.count), 32'd0);
    chk("bad_funct_err",   32'(bus.err), 32'd1);
`else
    chk("any_funct_we",    32'(bus.imem_we), 32'd1);
    chk("any_funct_wdata", bus.imem_wdata, 32'h0021_083F);
    chk("any_funct_err",   32'(bus.err), 32'd0);
`endif
    drive(1'b1, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    chk("sub_we",    32'(bus.imem_we), 32'd1);
    chk("sub_wdata", bus.imem_wdata, 32'h0085_3022);
`ifdef RTYPE_FUNCT_CHECK_EN
    chk("sub_addr",  32'(bus.imem_addr), 32'd0);
    chk("sub_count", 32'(bus.count), 32'd1);
    chk("sub_err",   32'(bus.err), 32'd1);
`else
    chk("sub_addr",  32'(bus.imem_addr), 32'd1);
    chk("sub_count", 32'(bus.count), 32'd2);
    chk("sub_err",   32'(bus.err), 32'd0);
`endif
    tick();
    chk("sub_done", 32'(bus.done), 32'd1);

    // Reset during a write cycle.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive(1'b1, 5'd7, 5'd8, 5'd9, 5'd0, 6'h24, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    chk("pre_rst_we", 32'(bus.imem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_we",       32'(bus.imem_we), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_count",    32'(bus.count), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd1, 5'd2, 6'h2A, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    chk("reload_addr",  32'(bus.imem_addr), 32'd0);
    chk("reload_wdata", bus.imem_wdata, 32'h0000_08AA);
    chk("reload_count", 32'(bus.count), 32'd1);

    // DEPTH=4: five bundles without in_last truncate after four writes.
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    bus4.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus4.in_rs = 5'(k);
      tick();
      chk($sformatf("d4_w%0d_we", k),    32'(bus4.imem_we), 32'd1);
      chk($sformatf("d4_w%0d_addr", k),  32'(bus4.imem_addr), 32'(k));
      chk($sformatf("d4_w%0d_wdata", k), bus4.imem_wdata, d4_wd[k]);
    end
    chk("d4_in_ready_full", 32'(bus4.in_ready), 32'd0);
    chk("d4_err_trunc",     32'(bus4.err), 32'd1);
    bus4.in_rs = 5'd4;
    tick();
    bus4.in_valid = 1'b0;
    chk("d4_fifth_we",  32'(bus4.imem_we), 32'd0);
    chk("d4_done",      32'(bus4.done), 32'd1);
    chk("d4_count",     32'(bus4.count), 32'd4);
    chk("d4_err",       32'(bus4.err), 32'd1);
    tick();
    chk("d4_count_hold", 32'(bus4.count), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
